// File: rtl/demod_decimator_if.sv
// Streaming port bundle for the decimator: sample input side and
// valid/ready result side.
interface demod_decimator_if #(
  parameter int DATA_W = 24
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // Decimator side: consumes samples, produces results.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data
  );

  // Environment side: drives samples, accepts results.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/demod_decimator.sv
// Integrate-and-dump decimator: averages each block of 2^LOG2_DECIM signed
// samples with round-half-up and queues the results in a small FIFO.
// A result that finds the FIFO full (with no simultaneous pop) is dropped
// and recorded in a sticky overflow flag.
module demod_decimator #(
  parameter int DATA_W     = 24,
  parameter int LOG2_DECIM = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  demod_decimator_if.slave    bus,
  input  logic                sync_clear,
  input  logic                clear_overflow,
  output logic                overflow
);

  localparam int ACC_W = DATA_W + LOG2_DECIM;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [LOG2_DECIM-1:0] SMP_ONE = LOG2_DECIM'(1);
  localparam logic [PTR_W-1:0]      PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) <<< (LOG2_DECIM - 1);

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W:0]    rounded;
  logic signed [ACC_W:0]    shifted;
  logic [LOG2_DECIM-1:0]    cnt;
  logic [DATA_W-1:0]        result;
  logic                     dump;

  logic [DATA_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         rd_ptr_next;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         count_next;
  logic [DATA_W-1:0]        head_next;
  logic                     pop;
  logic                     push_ok;
  logic                     drop;

  // Block sum including the current sample, then round-half-up and scale.
  always_comb begin
    sum     = acc + {{LOG2_DECIM{bus.in_data[DATA_W-1]}}, bus.in_data};
    rounded = {sum[ACC_W-1], sum} + HALF;
    shifted = rounded >>> LOG2_DECIM;
    result  = shifted[DATA_W-1:0];
  end

  assign dump    = bus.in_valid && (cnt == '1) && !sync_clear;
  assign pop     = bus.out_valid && bus.out_ready && !sync_clear;
  assign push_ok = dump && ((count != CNT_FULL) || pop);
  assign drop    = dump && (count == CNT_FULL) && !pop;

  // Integrate accepted samples; dump clears the block.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (sync_clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (bus.in_valid) begin
      if (cnt == '1) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + SMP_ONE;
      end
    end
  end

  // Next read pointer, occupancy and the value that will sit at the head.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    rd_ptr_next = rd_ptr;
    count_next  = count;
    if (pop) rd_ptr_next = rd_ptr + PTR_ONE;
    unique case ({push_ok, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
    head_next = (push_ok && (wr_ptr == rd_ptr_next)) ? result : mem[rd_ptr_next];
  end

  // Result storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; occupancy decides which entries
    // are meaningful, and out_data has its own reset register.
    if (push_ok) mem[wr_ptr] <= result;
  end

  // FIFO pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.out_data <= '0;
    end else if (sync_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      if (count_next != '0) bus.out_data <= head_next;
    end
  end

  assign bus.out_valid = (count != '0);

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

endmodule
